// File: rtl/prefetch_pkg.sv
// Shared types for the instruction prefetch stage: default widths, opcode
// encoding and the {pc, instr} entry carried through the prefetch FIFO.
package prefetch_pkg;

  localparam int PF_ADDR_W = 3;
  localparam int PF_DATA_W = 8;

  typedef enum logic [1:0] {
    OP_LD  = 2'b00,
    OP_ADD = 2'b01,
    OP_JMP = 2'b10,
    OP_JZ  = 2'b11
  } opcode_t;

  typedef struct packed {
    logic [PF_ADDR_W-1:0] pc;
    logic [PF_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Synchronous FIFO with flush; read data is forced to zero while empty so the
// consumer-facing outputs are clean when nothing is buffered.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_prefetch.sv
// Fetch stage: walks fetch_pc through a 1-cycle-latency instruction memory,
// buffers {pc, instr} in a FIFO and flushes everything on a redirect.
module instr_prefetch
  import prefetch_pkg::*;
#(
  parameter int ADDR_W = PF_ADDR_W,
  parameter int DATA_W = PF_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = $bits(fetch_entry_t);

  logic [ADDR_W-1:0] fetch_pc, rd_pc;
  logic              rd_pending;
  logic [CNT_W-1:0]  count;
  logic              full, empty, push;
  fetch_entry_t      wentry, hentry;

  // Credit counts the in-flight read as occupied; a same-cycle pop is not
  // credited, so the FIFO can never be pushed while full.
  assign mem_en   = !rst && !redirect_valid &&
                    (({1'b0, count} + {{CNT_W{1'b0}}, rd_pending}) < (CNT_W+1)'(DEPTH));
  assign mem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= '0;
      rd_pc      <= '0;
      rd_pending <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc   <= redirect_pc;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= mem_en;
      if (mem_en) begin
        rd_pc    <= fetch_pc;
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
    end
  end

  assign push          = rd_pending && !redirect_valid && !full;
  assign wentry.pc     = rd_pc;
  assign wentry.instr  = mem_rdata;

  sync_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .wdata (wentry),
    .pop   (out_ready),
    .rdata (hentry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_instr = hentry.instr;
  assign out_pc    = hentry.pc;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with a synchronous-read memory model.
module tb_instr_prefetch;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;

  logic [DATA_W-1:0] imem [8];
  int total = 0;
  int bad   = 0;

  instr_prefetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= imem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after posedge; outputs are sampled at the negedge.
  task automatic mid(); @(negedge clk); endtask
  task automatic nxt(); @(posedge clk); #1; endtask

  task automatic expect_out(input string tag, input int p);
    chk({tag, ".v"},   32'(out_valid), 32'd1);
    chk({tag, ".pc"},  32'(out_pc),    32'(p % 8));
    chk({tag, ".ins"}, 32'(out_instr), 32'(imem[p % 8]));
  endtask

  // Leaves the bench at the start of cycle R (rst just dropped).
  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0;
    nxt();
    mid();
    chk("rst.mem_en", 32'(mem_en),    32'd0);
    chk("rst.valid",  32'(out_valid), 32'd0);
    chk("rst.instr",  32'(out_instr), 32'd0);
    chk("rst.pc",     32'(out_pc),    32'd0);
    chk("rst.addr",   32'(mem_addr),  32'd0);
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    int exp_pc;
    int pops;
    imem[0] = 8'h03; imem[1] = 8'h05; imem[2] = 8'h42; imem[3] = 8'h86;
    imem[4] = 8'hCD; imem[5] = 8'h87; imem[6] = 8'h43; imem[7] = 8'h01;

    // free run with wrap
    out_ready = 1'b1;
    do_reset();
    mid();
    chk("fr.R.en",   32'(mem_en),    32'd1);
    chk("fr.R.addr", 32'(mem_addr),  32'd0);
    chk("fr.R.v",    32'(out_valid), 32'd0);
    nxt(); mid();
    chk("fr.R1.v",   32'(out_valid), 32'd0);
    nxt();
    for (int i = 0; i < 9; i++) begin
      mid(); expect_out("fr", i); nxt();
    end

    // backpressure
    out_ready = 1'b0;
    do_reset();
    repeat (9) nxt();
    mid();
    chk("bp.en", 32'(mem_en), 32'd0);
    expect_out("bp.hold", 0);
    nxt();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid(); expect_out("bp.rel", i); nxt();
    end

    // redirect with a read in flight
    out_ready = 1'b1;
    do_reset();
    repeat (3) nxt();
    redirect_valid = 1'b1; redirect_pc = 3'd5;
    mid();
    chk("rd.R3.en", 32'(mem_en), 32'd0);
    nxt();
    redirect_valid = 1'b0;
    mid();
    chk("rd.R4.v",    32'(out_valid), 32'd0);
    chk("rd.R4.en",   32'(mem_en),    32'd1);
    chk("rd.R4.addr", 32'(mem_addr),  32'd5);
    nxt(); mid();
    chk("rd.R5.v", 32'(out_valid), 32'd0);
    nxt(); mid(); expect_out("rd.R6", 5);
    nxt(); mid(); expect_out("rd.R7", 6);
    nxt();

    // redirect during a pop, then back-to-back redirects 2 then 6
    out_ready = 1'b1;
    do_reset();
    repeat (4) nxt();
    redirect_valid = 1'b1; redirect_pc = 3'd2;
    mid(); expect_out("bb.R4", 2);
    nxt();
    redirect_pc = 3'd6;
    mid();
    chk("bb.R5.v", 32'(out_valid), 32'd0);
    nxt();
    redirect_valid = 1'b0;
    mid();
    chk("bb.R6.addr", 32'(mem_addr),  32'd6);
    chk("bb.R6.v",    32'(out_valid), 32'd0);
    nxt(); mid();
    chk("bb.R7.v", 32'(out_valid), 32'd0);
    nxt(); mid(); expect_out("bb.R8", 6);
    nxt(); mid(); expect_out("bb.R9", 7);
    nxt();

    // reset with a full FIFO
    out_ready = 1'b0;
    do_reset();
    repeat (8) nxt();
    mid();
    chk("mr.full.en", 32'(mem_en), 32'd0);
    expect_out("mr.full", 0);
    nxt();
    rst = 1'b1;
    mid();
    chk("mr.rst.en", 32'(mem_en), 32'd0);
    nxt();
    rst = 1'b0; out_ready = 1'b1;
    mid();
    chk("mr.R.v",    32'(out_valid), 32'd0);
    chk("mr.R.en",   32'(mem_en),    32'd1);
    chk("mr.R.addr", 32'(mem_addr),  32'd0);
    nxt(); mid();
    chk("mr.R1.v", 32'(out_valid), 32'd0);
    nxt(); mid(); expect_out("mr.R2", 0);
    nxt();

    // random out_ready: head is always the next contiguous pc
    do_reset();
    exp_pc = 0;
    pops   = 0;
    for (int i = 0; i < 200; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      mid();
      if (out_valid) begin
        chk("rnd.pc",  32'(out_pc),    32'(exp_pc % 8));
        chk("rnd.ins", 32'(out_instr), 32'(imem[exp_pc % 8]));
        if (out_ready) begin
          exp_pc++;
          pops++;
        end
      end
      nxt();
    end
    chk("rnd.progress", 32'(pops > 40), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
